// File: rtl/passive_alarm_pkg.sv
// Shared state encoding and default delays for the passive car alarm.
package passive_alarm_pkg;

   typedef enum logic [2:0] {
      DISARMED = 3'd0,
      ARMING   = 3'd1,
      ARMED    = 3'd2,
      ENTRY    = 3'd3,
      ALARM    = 3'd4
   } alarmState_t;

   localparam int DEF_ARM_DELAY   = 8;
   localparam int DEF_ENTRY_DELAY = 6;
   localparam int DEF_SIREN_TIME  = 10;
   localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/passive_alarm_timer.sv
// Loadable down-counter with zero flag; decrement saturates at zero.
module passive_alarm_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] loadValue,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   // Load has priority over decrement; count never wraps below zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= loadValue;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/passive_alarm_ctrl.sv
// Passive car alarm controller: arms after doors close with ignition off,
// grants an entry grace period, sounds a timed siren, warns on lights left on.
// Optional confirmation chirp enabled by defining PASSIVE_ALARM_CHIRP_EN.
module passive_alarm_ctrl
   import passive_alarm_pkg::*;
#(
   parameter int ARM_DELAY   = DEF_ARM_DELAY,
   parameter int ENTRY_DELAY = DEF_ENTRY_DELAY,
   parameter int SIREN_TIME  = DEF_SIREN_TIME,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       IgnitionSignalOn,
   input  logic       OpenDoorSign,
   input  logic       CarLightsOnSign,
   input  logic       DisarmKey,
   output logic       Armed,
   output logic       SirenOn,
   output logic       PassiveSignal,
   output logic       Chirp,
   output logic [2:0] AlarmState
);

   localparam logic [CNT_W-1:0] ARM_LOAD   = CNT_W'(ARM_DELAY - 1);
   localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
   localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);

   alarmState_t      state;
   alarmState_t      nextState;
   logic             timerLoad;
   logic             timerDec;
   logic [CNT_W-1:0] timerValue;
   logic             timerZero;

   passive_alarm_timer #(
      .CNT_W(CNT_W)
   ) timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timerLoad),
      .loadValue(timerValue),
      .dec      (timerDec),
      .zero     (timerZero)
   );

   // State register and registered outputs derived from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= DISARMED;
         Armed         <= 1'b0;
         SirenOn       <= 1'b0;
         PassiveSignal <= 1'b0;
      end else begin
         state         <= nextState;
         Armed         <= (nextState == ARMED) || (nextState == ENTRY);
         SirenOn       <= (nextState == ALARM);
         PassiveSignal <= CarLightsOnSign & OpenDoorSign & ~IgnitionSignalOn;
      end
   end

   // Next-state and timer control; disarm key overrides every transition.
   always_comb begin
      nextState  = state;
      timerLoad  = 1'b0;
      timerDec   = 1'b0;
      timerValue = '0;
      if (DisarmKey) begin
         nextState = DISARMED;
      end else begin
         case (state)
            DISARMED: begin
               if (!IgnitionSignalOn && !OpenDoorSign) begin
                  nextState  = ARMING;
                  timerLoad  = 1'b1;
                  timerValue = ARM_LOAD;
               end
            end
            ARMING: begin
               if (OpenDoorSign || IgnitionSignalOn) begin
                  nextState = DISARMED;
               end else if (timerZero) begin
                  nextState = ARMED;
               end else begin
                  timerDec = 1'b1;
               end
            end
            ARMED: begin
               if (IgnitionSignalOn) begin
                  nextState  = ALARM;
                  timerLoad  = 1'b1;
                  timerValue = SIREN_LOAD;
               end else if (OpenDoorSign) begin
                  nextState  = ENTRY;
                  timerLoad  = 1'b1;
                  timerValue = ENTRY_LOAD;
               end
            end
            ENTRY: begin
               if (IgnitionSignalOn || timerZero) begin
                  nextState  = ALARM;
                  timerLoad  = 1'b1;
                  timerValue = SIREN_LOAD;
               end else begin
                  timerDec = 1'b1;
               end
            end
            ALARM: begin
               if (timerZero) begin
                  nextState = ARMED;
               end else begin
                  timerDec = 1'b1;
               end
            end
            default: nextState = DISARMED;
         endcase
      end
   end

   assign AlarmState = state;

`ifdef PASSIVE_ALARM_CHIRP_EN
   logic chirpNext;

   // Chirp confirms arming completion and disarming from an armed-family state.
   always_comb begin
      chirpNext = 1'b0;
      if ((state == ARMING) && (nextState == ARMED)) begin
         chirpNext = 1'b1;
      end else if ((nextState == DISARMED) &&
                   ((state == ARMED) || (state == ENTRY) || (state == ALARM))) begin
         chirpNext = 1'b1;
      end
   end

   // Register the chirp pulse alongside the other outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         Chirp <= 1'b0;
      end else begin
         Chirp <= chirpNext;
      end
   end
`else
   assign Chirp = 1'b0;
`endif

endmodule
